// File: rtl/ras_req_sched.sv
// rtl/ras_req_sched.sv - return address stack request scheduler
// Queues up to two call/return requests per cycle and issues one stack operation per cycle.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module ras_req_sched #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [1:0]                 fetch_rassched_valid,
  input  logic [1:0]                 fetch_rassched_push,
  input  logic [1:0]                 fetch_rassched_pop,
  input  logic [2*`ADDR_WIDTH-1:0]   fetch_rassched_addr,
  output logic                       rassched_fetch_ready,
  input  logic                       commit_rassched_flush,
  output logic                       rassched_ras_push,
  output logic                       rassched_ras_pop,
  output logic [`ADDR_WIDTH-1:0]     rassched_ras_addr,
  output logic                       rassched_busy,
  output logic                       rassched_csrf_stall_add
);

  localparam int AW = `ADDR_WIDTH;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] READY_MAX = CW'(FIFO_DEPTH - 2);

  logic          ent_push [FIFO_DEPTH];
  logic          ent_pop  [FIFO_DEPTH];
  logic [AW-1:0] ent_addr [FIFO_DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic          ready;
  logic          slot0_req;
  logic          slot1_req;
  logic          enq_fire;
  logic [1:0]    enq_cnt;
  logic [1:0]    deq_cnt;
  logic [PW-1:0] wr1_ptr;
  logic [PW-1:0] rd_nxt;
  logic          fuse;
  logic          issue_push;
  logic          issue_pop;
  logic [AW-1:0] issue_addr;

  // Two free slots are needed so fetch can always present a full pair.
  assign ready                = rst_n && (count <= READY_MAX);
  assign rassched_fetch_ready = ready;
  assign rassched_busy        = (count != '0);

  always_comb begin
    slot0_req = fetch_rassched_valid[0] && (fetch_rassched_push[0] || fetch_rassched_pop[0]);
    slot1_req = fetch_rassched_valid[1] && (fetch_rassched_push[1] || fetch_rassched_pop[1]);
    enq_fire  = ready && !commit_rassched_flush;
    enq_cnt   = enq_fire ? ({1'b0, slot0_req} + {1'b0, slot1_req}) : 2'd0;
    wr1_ptr   = slot0_req ? wr_ptr + PW'(1) : wr_ptr;
    rd_nxt    = rd_ptr + PW'(1);

    // Return followed directly by a call collapses into one push+pop.
    fuse = (count >= CW'(2))
        && ent_pop[rd_ptr] && !ent_push[rd_ptr]
        && ent_push[rd_nxt] && !ent_pop[rd_nxt];

    deq_cnt    = 2'd0;
    issue_push = 1'b0;
    issue_pop  = 1'b0;
    issue_addr = ent_addr[rd_ptr];
    if (count != '0) begin
      if (fuse) begin
        deq_cnt    = 2'd2;
        issue_push = 1'b1;
        issue_pop  = 1'b1;
        issue_addr = ent_addr[rd_nxt];
      end else begin
        deq_cnt    = 2'd1;
        issue_push = ent_push[rd_ptr];
        issue_pop  = ent_pop[rd_ptr];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (enq_fire) begin
      if (slot0_req) begin
        ent_push[wr_ptr] <= fetch_rassched_push[0];
        ent_pop[wr_ptr]  <= fetch_rassched_pop[0];
        ent_addr[wr_ptr] <= fetch_rassched_addr[0 +: AW];
      end
      if (slot1_req) begin
        ent_push[wr1_ptr] <= fetch_rassched_push[1];
        ent_pop[wr1_ptr]  <= fetch_rassched_pop[1];
        ent_addr[wr1_ptr] <= fetch_rassched_addr[AW +: AW];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr                  <= '0;
      rd_ptr                  <= '0;
      count                   <= '0;
      rassched_ras_push       <= 1'b0;
      rassched_ras_pop        <= 1'b0;
      rassched_ras_addr       <= '0;
      rassched_csrf_stall_add <= 1'b0;
    end else if (commit_rassched_flush) begin
      wr_ptr                  <= '0;
      rd_ptr                  <= '0;
      count                   <= '0;
      rassched_ras_push       <= 1'b0;
      rassched_ras_pop        <= 1'b0;
      rassched_csrf_stall_add <= 1'b0;
    end else begin
      wr_ptr                  <= wr_ptr + PW'(enq_cnt);
      rd_ptr                  <= rd_ptr + PW'(deq_cnt);
      count                   <= count + CW'(enq_cnt) - CW'(deq_cnt);
      rassched_ras_push       <= issue_push;
      rassched_ras_pop        <= issue_pop;
      if (issue_push) begin
        rassched_ras_addr <= issue_addr;
      end
      rassched_csrf_stall_add <= (|fetch_rassched_valid) && !ready;
    end
  end

endmodule
